// File: rtl/arbiter_rr4_pkg.sv
// Shared definitions for the four-master round-robin arbiter:
// state encodings, requester count and hold counter width.
package arbiter_rr4_pkg;

   localparam int N_REQ  = 4;
   localparam int IDX_W  = 2;
   localparam int HOLD_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN = 2'd2
   } arb_state_e;

   function automatic logic [N_REQ-1:0] idx_onehot(
      input logic [IDX_W-1:0] idx
   );
      return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/arbiter_rr4_pick.sv
// Rotating-priority encoder: first active request at or after ptr,
// wrapping modulo four.
module rr_priority_pick
   import arbiter_rr4_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] cand;

   // Walk from the farthest candidate back to ptr so the nearest wins.
   always_comb begin
      valid = 1'b0;
      idx   = ptr;
      cand  = ptr;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = ptr + IDX_W'(k);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/arbiter_rr4.sv
// Four-requester round-robin arbiter with bounded grant tenure and
// a mandatory one-cycle turnaround between grants.
module arbiter_rr4
   import arbiter_rr4_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_0,
   input  logic             req_1,
   input  logic             req_2,
   input  logic             req_3,
   output logic             gnt_0,
   output logic             gnt_1,
   output logic             gnt_2,
   output logic             gnt_3,
   output logic             busy,
   output logic [IDX_W-1:0] owner
);

   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;

   logic [N_REQ-1:0]  req_vec;
   logic              pick_valid;
   logic [IDX_W-1:0]  pick_idx;

   assign req_vec = {req_3, req_2, req_1, req_0};

   rr_priority_pick u_pick (
      .req   (req_vec),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      unique case (state_q)
         ST_IDLE, ST_TURN: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
            if (pick_valid) begin
               state_d = ST_GRANT;
               owner_d = pick_idx;
               hold_d  = HOLD_W'(1);
               gnt_d   = idx_onehot(pick_idx);
            end
         end
         ST_GRANT: begin
            // Timeout releases even with the owner still requesting.
            if (!req_vec[owner_q] || hold_q == HOLD_MAX) begin
               state_d = ST_TURN;
               gnt_d   = '0;
               ptr_d   = owner_q + IDX_W'(1);
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         hold_q  <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
      end
   end

   assign {gnt_3, gnt_2, gnt_1, gnt_0} = gnt_q;
   assign busy  = |gnt_q;
   assign owner = busy ? owner_q : '0;

endmodule

// File: tb/tb_arbiter_rr4.sv
// Directed and random checks of arbiter_rr4 against a round-robin
// reference model expressed as owner/tenure/pointer bookkeeping.
module tb_arbiter_rr4;

   localparam int MH = 4;

   logic       clock;
   logic       reset;
   logic       req_0, req_1, req_2, req_3;
   logic       gnt_0, gnt_1, gnt_2, gnt_3;
   logic       busy;
   logic [1:0] owner;
   logic [3:0] gnt_vec;

   int total = 0;
   int bad   = 0;

   int m_owner;
   int m_ten;
   int m_ptr;

   arbiter_rr4 #(.MAX_HOLD(MH)) dut (
      .clock (clock),
      .reset (reset),
      .req_0 (req_0),
      .req_1 (req_1),
      .req_2 (req_2),
      .req_3 (req_3),
      .gnt_0 (gnt_0),
      .gnt_1 (gnt_1),
      .gnt_2 (gnt_2),
      .gnt_3 (gnt_3),
      .busy  (busy),
      .owner (owner)
   );

   assign gnt_vec = {gnt_3, gnt_2, gnt_1, gnt_0};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic model_reset();
      m_owner = -1;
      m_ten   = 0;
      m_ptr   = 0;
   endtask

   function automatic int model_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   // Idle and turnaround look alike from outside: both pick on the edge.
   task automatic model_step(input logic [3:0] r);
      int w;
      if (m_owner < 0) begin
         w = model_pick(r, m_ptr);
         if (w >= 0) begin
            m_owner = w;
            m_ten   = 1;
         end
      end else if (!r[m_owner] || m_ten == MH) begin
         m_ptr   = (m_owner + 1) % 4;
         m_owner = -1;
         m_ten   = 0;
      end else begin
         m_ten++;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [3:0] e_gnt;
      logic [1:0] e_own;
      int         o;
      o     = (m_owner < 0) ? 0 : m_owner;
      e_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      e_own = o[1:0];
      total++;
      assert (gnt_vec === e_gnt) else begin
         bad++;
         $error("FAIL %s gnt got=%b exp=%b", tag, gnt_vec, e_gnt);
      end
      total++;
      assert (busy === (m_owner >= 0)) else begin
         bad++;
         $error("FAIL %s busy got=%b exp=%b", tag, busy, m_owner >= 0);
      end
      total++;
      assert (owner === e_own) else begin
         bad++;
         $error("FAIL %s owner got=%0d exp=%0d", tag, owner, e_own);
      end
      total++;
      assert ($onehot0(gnt_vec) && busy === (|gnt_vec)) else begin
         bad++;
         $error("FAIL %s invariant gnt=%b busy=%b", tag, gnt_vec, busy);
      end
   endtask

   task automatic cyc(input logic [3:0] r, input string tag);
      {req_3, req_2, req_1, req_0} = r;
      @(posedge clock);
      model_step(r);
      #1;
      check_outputs(tag);
   endtask

   task automatic do_reset();
      {req_3, req_2, req_1, req_0} = 4'b0000;
      reset = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #3;
      reset = 1'b0;
      model_reset();
      check_outputs("reset");
   endtask

   initial begin
      int         own_q[$];
      int         len_q[$];
      int         len;
      logic       prev;
      logic [11:0] pat;
      logic [3:0] r;
      int         exp_own[5];

      reset = 1'b1;
      {req_3, req_2, req_1, req_0} = 4'b0000;
      model_reset();
      do_reset();

      // Single requester: grant, release, gap, idle.
      cyc(4'b0100, "req2_grant");
      cyc(4'b0100, "req2_hold");
      cyc(4'b0000, "req2_release");
      cyc(4'b0000, "req2_idle");

      // All four requesting: order and tenure length.
      do_reset();
      prev = 1'b0;
      len  = 0;
      for (int i = 0; i < 25; i++) begin
         cyc(4'b1111, "all4");
         if (busy && !prev) begin
            own_q.push_back(int'(owner));
            len = 0;
         end
         if (busy) len++;
         if (!busy && prev) len_q.push_back(len);
         prev = busy;
      end
      exp_own = '{0, 1, 2, 3, 0};
      total++;
      assert (own_q.size() == 5 && len_q.size() == 5) else begin
         bad++;
         $error("FAIL all4_count got=%0d/%0d exp=5/5",
                own_q.size(), len_q.size());
      end
      for (int i = 0; i < 5 && i < own_q.size() && i < len_q.size(); i++) begin
         total++;
         assert (own_q[i] == exp_own[i] && len_q[i] == MH) else begin
            bad++;
            $error("FAIL all4_seq[%0d] got=%0d/%0d exp=%0d/%0d",
                   i, own_q[i], len_q[i], exp_own[i], MH);
         end
      end

      // Single master held past timeout gets regranted after the gap.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         cyc(4'b0010, "req1_hold");
         pat[11-i] = gnt_1;
      end
      total++;
      assert (pat === 12'b1111_0111_1011) else begin
         bad++;
         $error("FAIL req1_pattern got=%b exp=%b", pat, 12'b1111_0111_1011);
      end
      cyc(4'b0000, "req1_drop");
      cyc(4'b0000, "req1_idle");

      // Move ptr to 2, then simultaneous req_0/req_3.
      do_reset();
      cyc(4'b0010, "ptr_setup");
      cyc(4'b0000, "ptr_setup_rel");
      cyc(4'b0000, "ptr_setup_idle");
      cyc(4'b1001, "r03_first");
      total++;
      assert (gnt_3 === 1'b1 && gnt_0 === 1'b0) else begin
         bad++;
         $error("FAIL r03_first got=%b exp=1000", gnt_vec);
      end
      cyc(4'b0001, "r03_rel");
      cyc(4'b0001, "r03_second");
      total++;
      assert (gnt_0 === 1'b1) else begin
         bad++;
         $error("FAIL r03_second got=%b exp=0001", gnt_vec);
      end
      cyc(4'b0000, "r03_drop");

      // Async reset mid-grant.
      do_reset();
      cyc(4'b0010, "mid_grant");
      cyc(4'b0010, "mid_hold");
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      total++;
      assert (gnt_vec === 4'b0000 && busy === 1'b0) else begin
         bad++;
         $error("FAIL async_reset got=%b/%b exp=0000/0", gnt_vec, busy);
      end
      check_outputs("async_reset");
      @(posedge clock);
      #3;
      reset = 1'b0;
      cyc(4'b0011, "post_reset");
      total++;
      assert (gnt_0 === 1'b1) else begin
         bad++;
         $error("FAIL post_reset got=%b exp=0001", gnt_vec);
      end

      // Random traffic with sticky request patterns.
      do_reset();
      r = 4'b0000;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         cyc(r, "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
